// File: rtl/audio_capture_pkg.sv
// Shared types and constants for the I2S audio capture slice.
// Holds the write FSM encoding and I2S bit-position markers.
package audio_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } wr_state_e;

  localparam logic [5:0] FRAME_START = 6'd0;
  localparam logic [5:0] LEFT_START  = 6'd1;
  localparam logic [5:0] RIGHT_START = 6'd33;
  localparam int         FRAME_LEN   = 64;

endpackage

// File: rtl/audio_capture_i2s_rx_line.sv
// One I2S data line: MSB-first left/right deserialiser
// plus holding registers snapshotted at a frame boundary.
module i2s_rx_line
  import audio_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                bit_en,
  input  logic                load,
  input  logic [5:0]          posn,
  input  logic                sd,
  output logic [SAMPLE_W-1:0] hold_l,
  output logic [SAMPLE_W-1:0] hold_r
);

  localparam logic [5:0] LEFT_END  = 6'(int'(LEFT_START) + SAMPLE_W);
  localparam logic [5:0] RIGHT_END = 6'(int'(RIGHT_START) + SAMPLE_W);

  logic                in_l;
  logic                in_r;
  logic [SAMPLE_W-1:0] sh_l_q, sh_l_d;
  logic [SAMPLE_W-1:0] sh_r_q, sh_r_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;

  assign in_l = (posn >= LEFT_START) && (posn < LEFT_END);
  assign in_r = (posn >= RIGHT_START) && (posn < RIGHT_END);

  // Shift on sampled bit positions, snapshot on load.
  always_comb begin
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    if (bit_en && in_l) sh_l_d = {sh_l_q[SAMPLE_W-2:0], sd};
    if (bit_en && in_r) sh_r_d = {sh_r_q[SAMPLE_W-2:0], sd};
    if (load) begin
      hold_l_d = sh_l_q;
      hold_r_d = sh_r_q;
    end
  end

  // Shift and holding register state.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      hold_l_q <= '0;
      hold_r_q <= '0;
    end else begin
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
    end
  end

  assign hold_l = hold_l_q;
  assign hold_r = hold_r_q;

endmodule

// File: rtl/audio_capture.sv
// Multi-line I2S capture: deserialises every line, then bursts
// one frame of samples into the audio RAM per frame boundary.
module audio_capture
  import audio_capture_pkg::*;
#(
  parameter  int DATA_LINES = 4,
  parameter  int SAMPLE_W   = 16,
  parameter  int FRAMES     = 64,
  localparam int CHANNELS   = 2 * DATA_LINES,
  localparam int CHAN_W     = $clog2(CHANNELS),
  localparam int FRAME_W    = $clog2(FRAMES),
  localparam int AUDIO_W    = CHAN_W + FRAME_W
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  sck,
  input  logic [5:0]            frame_posn,
  input  logic [DATA_LINES-1:0] sd_in,
  input  logic                  enable,
  input  logic                  host_mode,
  input  logic [FRAME_W-1:0]    host_frame,
  input  logic                  clr_overrun,
  output logic                  ram_we,
  output logic [AUDIO_W-1:0]    ram_waddr,
  output logic [SAMPLE_W-1:0]   ram_wdata,
  output logic [FRAME_W-1:0]    frame,
  output logic                  frame_done,
  output logic                  overrun
);

  localparam logic [CHAN_W-1:0] LAST_CH = CHAN_W'(CHANNELS - 1);

  wr_state_e           state_q, state_d;
  logic [CHAN_W-1:0]   chan_q, chan_d;
  logic [FRAME_W-1:0]  fc_q, fc_d;
  logic                ovr_q, ovr_d;
  logic                sck_q;
  logic                hist_q;
  logic                sck_rise;
  logic                boundary;
  logic                load;
  logic                we;
  logic                done;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] hold_l [DATA_LINES];
  logic [SAMPLE_W-1:0] hold_r [DATA_LINES];

  // hist_q masks a false edge when sck is already high at reset release.
  assign sck_rise = sck && !sck_q && hist_q;
  assign boundary = sck_rise && (frame_posn == FRAME_START);
  // Holding data is frozen while a burst is still draining it.
  assign load     = boundary && (state_q == ST_IDLE);

  for (genvar k = 0; k < DATA_LINES; k++) begin : g_line
    i2s_rx_line #(
      .SAMPLE_W(SAMPLE_W)
    ) u_line (
      .ck    (ck),
      .rst   (rst),
      .bit_en(sck_rise),
      .load  (load),
      .posn  (frame_posn),
      .sd    (sd_in[k]),
      .hold_l(hold_l[k]),
      .hold_r(hold_r[k])
    );
  end

  // Channel mux: even channel = left, odd = right of line chan/2.
  always_comb begin
    sample = '0;
    for (int k = 0; k < DATA_LINES; k++) begin
      if (chan_q == CHAN_W'(2 * k))     sample = hold_l[k];
      if (chan_q == CHAN_W'(2 * k + 1)) sample = hold_r[k];
    end
  end

  // Write FSM next state, counters, overrun and strobes.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    fc_d    = fc_q;
    ovr_d   = ovr_q;
    we      = 1'b0;
    done    = 1'b0;
    if (clr_overrun) ovr_d = 1'b0;
    if (boundary && (state_q != ST_IDLE)) ovr_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (boundary && enable && !host_mode) begin
          state_d = ST_WRITE;
          chan_d  = '0;
          fc_d    = fc_q + FRAME_W'(1);
        end
      end
      ST_WRITE: begin
        we = 1'b1;
        if (chan_q == LAST_CH) state_d = ST_DONE;
        else                   chan_d  = chan_q + CHAN_W'(1);
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (host_mode) begin
      we      = 1'b0;
      done    = 1'b0;
      state_d = ST_IDLE;
    end
  end

  // FSM, counter, overrun and sck history registers.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      fc_q    <= '0;
      ovr_q   <= 1'b0;
      sck_q   <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      fc_q    <= fc_d;
      ovr_q   <= ovr_d;
      sck_q   <= sck;
      hist_q  <= 1'b1;
    end
  end

  assign ram_we     = we;
  assign ram_waddr  = we ? {chan_q, fc_q} : '0;
  assign ram_wdata  = we ? sample : '0;
  assign frame      = host_mode ? host_frame : fc_q;
  assign frame_done = done;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_audio_capture.sv
// Scoreboard bench for audio_capture: random I2S frames,
// expected RAM bursts queued, monitor compares on negedge.
module tb_audio_capture;

  localparam int DL = 4;
  localparam int SW = 16;
  localparam int FR = 64;
  localparam int CH = 2 * DL;
  localparam int FW = $clog2(FR);
  localparam int AW = $clog2(CH) + FW;

  typedef struct packed {
    logic          dn;
    logic [AW-1:0] a;
    logic [SW-1:0] d;
  } exp_t;

  logic          ck = 1'b0;
  logic          rst;
  logic          sck;
  logic [5:0]    frame_posn;
  logic [DL-1:0] sd_in;
  logic          enable;
  logic          host_mode;
  logic [FW-1:0] host_frame;
  logic          clr_overrun;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [SW-1:0] ram_wdata;
  logic [FW-1:0] frame;
  logic          frame_done;
  logic          overrun;

  int   tests = 0;
  int   fails = 0;
  int   fc    = 0;
  exp_t exp_q[$];
  logic [SW-1:0] lv[DL];
  logic [SW-1:0] rv[DL];

  always #5 ck = ~ck;

  audio_capture #(
    .DATA_LINES(DL),
    .SAMPLE_W  (SW),
    .FRAMES    (FR)
  ) dut (
    .ck         (ck),
    .rst        (rst),
    .sck        (sck),
    .frame_posn (frame_posn),
    .sd_in      (sd_in),
    .enable     (enable),
    .host_mode  (host_mode),
    .host_frame (host_frame),
    .clr_overrun(clr_overrun),
    .ram_we     (ram_we),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .frame      (frame),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic sck_bit(input logic [5:0] p, input logic [DL-1:0] d);
    sck = 1'b1;
    frame_posn = p;
    sd_in = d;
    tick();
    sck = 1'b0;
    tick();
  endtask

  task automatic rand_samples();
    for (int k = 0; k < DL; k++) begin
      lv[k] = SW'($urandom);
      rv[k] = SW'($urandom);
    end
  endtask

  // Positions 1..63 of a frame; unused positions carry random noise.
  task automatic send_body();
    for (int p = 1; p < FR; p++) begin
      logic [DL-1:0] d;
      d = DL'($urandom);
      for (int k = 0; k < DL; k++) begin
        if (p >= 1 && p <= SW)           d[k] = lv[k][SW-p];
        else if (p >= 33 && p <= 32 + SW) d[k] = rv[k][32+SW-p];
      end
      sck_bit(6'(p), d);
    end
  endtask

  // Reference: accepted frame -> next frame index, then channels in order.
  task automatic push_burst(input int nch, input bit with_done);
    exp_t e;
    fc = (fc + 1) % FR;
    for (int c = 0; c < nch; c++) begin
      e.dn = 1'b0;
      e.a  = AW'(c * FR + fc);
      e.d  = (c % 2 == 0) ? lv[c/2] : rv[c/2];
      exp_q.push_back(e);
    end
    if (with_done) begin
      e = '0;
      e.dn = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input bit acc);
    send_body();
    if (acc) push_burst(CH, 1'b1);
    sck_bit(6'd0, DL'($urandom));
    chk("frame_after_boundary", 32'(frame), 32'(fc));
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge ck) begin
    if (ram_we || frame_done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {30'd0, ram_we, frame_done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ram_we) begin
          chk("write_not_done", 32'(e.dn), 32'd0);
          chk("ram_waddr", 32'(ram_waddr), 32'(e.a));
          chk("ram_wdata", 32'(ram_wdata), 32'(e.d));
        end else begin
          chk("frame_done_expected", 32'(e.dn), 32'd1);
        end
      end
    end else begin
      chk("idle_zero", {ram_waddr, ram_wdata}, 32'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    sck = 1'b0;
    frame_posn = '0;
    sd_in = '0;
    enable = 1'b1;
    host_mode = 1'b0;
    host_frame = '0;
    clr_overrun = 1'b0;
    repeat (3) tick();
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_frame", 32'(frame), 32'd0);
    chk("reset_overrun", 32'(overrun), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    rst = 1'b1;
    tick();

    // Known pattern with explicit latency checks.
    for (int k = 0; k < DL; k++) begin
      lv[k] = SW'(16'h1000 + k);
      rv[k] = SW'(16'h2000 + k);
    end
    send_body();
    push_burst(CH, 1'b1);
    sck = 1'b1;
    frame_posn = 6'd0;
    tick();
    chk("first_we_latency", 32'(ram_we), 32'd1);
    chk("first_waddr", 32'(ram_waddr), 32'(1));
    sck = 1'b0;
    repeat (CH - 1) tick();
    chk("last_we", 32'(ram_we), 32'd1);
    chk("done_not_early", 32'(frame_done), 32'd0);
    tick();
    chk("frame_done_latency", 32'(frame_done), 32'd1);
    tick();
    chk("frame_one", 32'(frame), 32'd1);

    // Remaining frames up to 64 from reset; last wraps to frame 0.
    for (int f = 1; f < FR; f++) begin
      rand_samples();
      send_frame(1'b1);
    end
    chk("frame_wrapped", 32'(frame), 32'd0);

    // Second boundary during a burst: overrun, old holding data kept.
    rand_samples();
    send_body();
    push_burst(CH, 1'b1);
    sck_bit(6'd0, '0);
    sck_bit(6'd1, '1);
    sck_bit(6'd0, '0);
    chk("overrun_set", 32'(overrun), 32'd1);
    repeat (8) tick();
    chk("overrun_sticky", 32'(overrun), 32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    chk("overrun_cleared", 32'(overrun), 32'd0);

    // Host takes the RAM at burst cycle 3.
    rand_samples();
    send_body();
    push_burst(3, 1'b0);
    sck = 1'b1;
    frame_posn = 6'd0;
    tick();
    sck = 1'b0;
    repeat (3) tick();
    host_mode = 1'b1;
    host_frame = FW'(5);
    #1;
    chk("host_we_drop", 32'(ram_we), 32'd0);
    chk("host_frame", 32'(frame), 32'd5);
    repeat (12) tick();
    chk("host_no_done", 32'(frame_done), 32'd0);
    host_mode = 1'b0;
    tick();
    chk("host_release_frame", 32'(frame), 32'(fc));

    // Enable dropped mid-burst: burst completes, then capture stops.
    rand_samples();
    send_body();
    push_burst(CH, 1'b1);
    sck_bit(6'd0, DL'($urandom));
    enable = 1'b0;
    rand_samples();
    send_frame(1'b0);
    repeat (12) tick();
    chk("enable_frame_holds", 32'(frame), 32'(fc));
    enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      rand_samples();
      send_frame(1'b1);
    end

    // Asynchronous reset in the middle of a burst.
    rand_samples();
    send_body();
    push_burst(1, 1'b0);
    sck_bit(6'd0, DL'($urandom));
    rst = 1'b0;
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    fc = 0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rand_samples();
    send_frame(1'b1);
    chk("post_rst_frame", 32'(frame), 32'd1);
    rand_samples();
    send_frame(1'b1);

    // Drain the scoreboard within a bounded window.
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
